bcd_preset_countdown: RTL and testbench

//   Parametrised successor to the fixed 2-digit preset logic: a preset-loadable multi-digit BCD countdown timer.
//   A select index picks a preset from a parameter table. A load pulse copies it into the counter.
//   The counter then counts down on an external tick strobe, with start/stop/pause control and optional

---
 rtl/bcd_preset_countdown.sv | 139 +++++++++++++
 tb/tb_bcd_preset_countdown.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_preset_countdown.sv
// Preset-loadable multi-digit BCD countdown timer.
// A preset picked from PRESET_TABLE by sel is loaded on a load pulse. Counting runs on
// the tick strobe under start/stop control, with optional auto-reload on expiry.
// Valid/ready note: every control input is a single-cycle strobe with no back-pressure;
// the block acts on a strobe at the edge where it is seen, and all outputs are registered.
module bcd_preset_countdown #(
    parameter int NUM_DIGITS = 2,
    parameter int N_PRESETS  = 8,
    parameter int SEL_W      = 3,
    parameter logic [N_PRESETS*NUM_DIGITS*4-1:0] PRESET_TABLE = 64'h5945302015100500
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    load,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    tick,
    input  logic                    auto_reload,
    output logic [NUM_DIGITS*4-1:0] count,
    output logic                    running,
    output logic                    expired,
    output logic                    done
);

    localparam int W = NUM_DIGITS * 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [W-1:0]   reload_val, reload_n;
    logic [W-1:0]   count_n;
    logic           done_n;
    logic           preset_hit;
    logic [W-1:0]   preset_val;
    logic [W-1:0]   count_one;

    assign count_one = {{(W-1){1'b0}}, 1'b1};

    // Clamp every non-BCD digit (A..F) to 9 so the counter only ever holds valid BCD.
    function automatic logic [W-1:0] saturate(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    // Subtract one in BCD: a zero digit becomes 9 and passes the borrow upward.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Look up the selected preset; an index beyond the table yields no hit.
    always_comb begin
        preset_hit = 1'b0;
        preset_val = '0;
        for (int i = 0; i < N_PRESETS; i++) begin
            if (int'(sel) == i) begin
                preset_hit = 1'b1;
                preset_val = saturate(PRESET_TABLE[i*W +: W]);
            end
        end
    end

    // Next state and datapath: load > stop > start > tick.
    always_comb begin
        state_n  = state;
        count_n  = count;
        reload_n = reload_val;
        done_n   = 1'b0;
        if (load && preset_hit) begin
            state_n  = IDLE;
            count_n  = preset_val;
            reload_n = preset_val;
        end else if (stop) begin
            // A tick in this cycle is dropped, and a coincident start is ignored.
            if (state == RUN) begin
                state_n = PAUSE;
            end
        end else if (start && (state == IDLE || state == PAUSE)) begin
            if (count != '0) begin
                state_n = RUN;
            end
        end else if (tick && state == RUN) begin
            if (count == count_one) begin
                done_n = 1'b1;
                if (auto_reload) begin
                    count_n = reload_val;
                end else begin
                    count_n = '0;
                    state_n = EXPIRED;
                end
            end else if (count != '0) begin
                count_n = bcd_dec(count);
            end
        end
    end

    // State, counter and flag registers; flags are decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            count      <= '0;
            reload_val <= '0;
            running    <= 1'b0;
            expired    <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            reload_val <= reload_n;
            running    <= (state_n == RUN);
            expired    <= (state_n == EXPIRED);
            done       <= done_n;
        end
    end

endmodule

// File: tb/tb_bcd_preset_countdown.sv
// Bench for bcd_preset_countdown: a default 2-digit instance and a 3-digit instance with
// a short table, both checked every cycle against a decimal-arithmetic reference model.
module tb_bcd_preset_countdown;

    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_PAUSE   = 2;
    localparam int M_EXPIRED = 3;

    typedef struct {
        int st;
        int cnt;
        int rld;
        int done;
    } mdl_t;

    logic        clk;
    logic        rst_n;
    logic        load, start, stop, tick, auto_reload;
    logic [2:0]  sel_a;
    logic [1:0]  sel_b;
    logic [7:0]  count_a;
    logic [11:0] count_b;
    logic        running_a, expired_a, done_a;
    logic        running_b, expired_b, done_b;

    int n_cmp;
    int n_err;
    mdl_t ma, mb;

    int preset_a[8] = '{0, 5, 10, 15, 20, 30, 45, 59};
    int preset_b[3] = '{100, 93, 250};

    bcd_preset_countdown u_dut_a (
        .clk(clk), .rst_n(rst_n), .sel(sel_a), .load(load), .start(start), .stop(stop),
        .tick(tick), .auto_reload(auto_reload), .count(count_a), .running(running_a),
        .expired(expired_a), .done(done_a)
    );

    bcd_preset_countdown #(
        .NUM_DIGITS(3), .N_PRESETS(3), .SEL_W(2),
        .PRESET_TABLE(36'h250_0A3_100)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .sel(sel_b), .load(load), .start(start), .stop(stop),
        .tick(tick), .auto_reload(auto_reload), .count(count_b), .running(running_b),
        .expired(expired_b), .done(done_b)
    );

    // Clock / reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] to_bcd(input int v, input int nd);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Reference behaviour in plain decimal terms.
    function automatic mdl_t model_next(input mdl_t m, input bit ld_ok, input int pv,
                                        input bit st, input bit sp, input bit tk, input bit ar);
        mdl_t n;
        n = m;
        n.done = 0;
        if (ld_ok) begin
            n.st  = M_IDLE;
            n.cnt = pv;
            n.rld = pv;
        end else if (sp) begin
            if (m.st == M_RUN) n.st = M_PAUSE;
        end else if (st && (m.st == M_IDLE || m.st == M_PAUSE)) begin
            if (m.cnt != 0) n.st = M_RUN;
        end else if (tk && m.st == M_RUN) begin
            if (m.cnt == 1) begin
                n.done = 1;
                if (ar) n.cnt = m.rld;
                else begin
                    n.cnt = 0;
                    n.st  = M_EXPIRED;
                end
            end else begin
                n.cnt = m.cnt - 1;
            end
        end
        return n;
    endfunction

    task automatic check_all();
        check("a_count",   32'(count_a),   to_bcd(ma.cnt, 2));
        check("a_running", 32'(running_a), 32'(ma.st == M_RUN));
        check("a_expired", 32'(expired_a), 32'(ma.st == M_EXPIRED));
        check("a_done",    32'(done_a),    32'(ma.done));
        check("b_count",   32'(count_b),   to_bcd(mb.cnt, 3));
        check("b_running", 32'(running_b), 32'(mb.st == M_RUN));
        check("b_expired", 32'(expired_b), 32'(mb.st == M_EXPIRED));
        check("b_done",    32'(done_b),    32'(mb.done));
    endtask

    // Driver: one cycle of inputs, then model update and check just after the edge.
    task automatic step(input bit ld, input int sa, input int sb, input bit st,
                        input bit sp, input bit tk, input bit ar);
        bit ld_b;
        @(negedge clk);
        load        = ld;
        sel_a       = 3'(sa);
        sel_b       = 2'(sb);
        start       = st;
        stop        = sp;
        tick        = tk;
        auto_reload = ar;
        @(posedge clk);
        ld_b = ld && (sb < 3);
        ma = model_next(ma, ld, preset_a[sa], st, sp, tk, ar);
        mb = model_next(mb, ld_b, ld_b ? preset_b[sb] : 0, st, sp, tk, ar);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        load = 0; start = 0; stop = 0; tick = 0; auto_reload = 0; sel_a = 0; sel_b = 0;
        ma = '{M_IDLE, 0, 0, 0};
        mb = '{M_IDLE, 0, 0, 0};
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        do_reset();

        // Load 10, count it down to expiry.
        step(1, 2, 0, 0, 0, 0, 0);
        check("t1_load", 32'(count_a), 32'h10);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t1_first_tick", 32'(count_a), 32'h09);
        for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 0, 1, 0);
        check("t1_done", 32'(done_a), 32'h1);
        step(0, 0, 0, 0, 0, 0, 0);
        check("t1_done_drop", 32'(done_a), 32'h0);
        check("t1_expired", 32'(expired_a), 32'h1);
        step(0, 0, 0, 1, 0, 1, 0);
        check("t6_expired_start", 32'(running_a), 32'h0);

        // Pause holds the count through ticks.
        step(1, 7, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0);
        check("t2_56", 32'(count_a), 32'h56);
        step(0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t2_paused", 32'(count_a), 32'h56);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0);
        check("t2_55", 32'(count_a), 32'h55);

        // Auto-reload keeps running.
        step(1, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 1);
        check("t3_done", 32'(done_a), 32'h1);
        check("t3_reload", 32'(count_a), 32'h05);
        check("t3_running", 32'(running_a), 32'h1);

        // Same-cycle priority.
        step(1, 4, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 3, 0, 0, 0, 1, 0);
        check("t4_load_tick", 32'(count_a), 32'h15);
        check("t4_idle", 32'(running_a), 32'h0);
        step(0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 1, 1, 0);
        check("t4_stop_tick", 32'(count_a), 32'h15);
        check("t4_paused", 32'(running_a), 32'h0);

        // Zero preset, 3-digit borrow, non-BCD saturation, out-of-table select.
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0);
        check("t5_zero_start", 32'(running_a), 32'h0);
        step(0, 0, 0, 1, 0, 1, 0);
        check("t5_b_running", 32'(running_b), 32'h1);
        check("t5_b_099", 32'(count_b), 32'h099);
        step(1, 0, 1, 0, 0, 0, 0);
        check("t5_b_sat", 32'(count_b), 32'h093);
        step(1, 2, 3, 1, 0, 0, 0);
        check("t5_b_badsel", 32'(count_b), 32'h093);
        check("t5_b_badsel_run", 32'(running_b), 32'h1);

        // Asynchronous reset between edges while done is high.
        step(1, 1, 0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_count", 32'(count_a), 32'h0);
        check("t6_rst_running", 32'(running_a), 32'h0);
        check("t6_rst_done", 32'(done_a), 32'h0);
        do_reset();

        // Random traffic against the model.
        begin
            bit ar;
            ar = 0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 49) == 0) ar = ~ar;
                step($urandom_range(0, 15) == 0, $urandom_range(0, 7), $urandom_range(0, 3),
                     $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0,
                     $urandom_range(0, 1) == 1, ar);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
